// File: rtl/if_fetch.sv
// Byte-serial instruction fetch: issues four byte reads per instruction over a shared
// memory port, assembles them little-endian and presents the word to if_id.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        mem_grant_i,
   input  logic [7:0]  mem_din_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        id_ready_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o
);

   typedef enum logic {FETCH = 1'b0, VALID = 1'b1} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [2:0]  issue_cnt_q;
   logic [1:0]  recv_cnt_q;
   logic        pending_q;
   logic [31:0] inst_buf_q;
   logic        if_valid_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_inst_q;

   logic        req_w;
   logic        issue_w;

   assign req_w   = (state_q == FETCH) && (issue_cnt_q < 3'd4);
   assign issue_w = req_w && mem_grant_i;

   // Outputs are forced low while reset is held, since the reset state is FETCH.
   assign mem_req_o  = rst && req_w;
   assign mem_addr_o = (rst && issue_w) ? (pc_q + {29'd0, issue_cnt_q}) : 32'd0;

   assign if_valid_o = if_valid_q;
   assign if_pc_o    = if_pc_q;
   assign if_inst_o  = if_inst_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         issue_cnt_q <= 3'd0;
         recv_cnt_q  <= 2'd0;
         pending_q   <= 1'b0;
         inst_buf_q  <= 32'd0;
         if_valid_q  <= 1'b0;
         if_pc_q     <= 32'd0;
         if_inst_q   <= 32'd0;
      end else if (rdy) begin
         if (branch_i) begin
            // Clearing pending drops any byte still in flight from the old stream.
            state_q     <= FETCH;
            pc_q        <= {branch_target_i[31:2], 2'b00};
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 2'd0;
            pending_q   <= 1'b0;
            if_valid_q  <= 1'b0;
         end else begin
            case (state_q)
               FETCH: begin
                  pending_q <= issue_w;
                  if (issue_w)
                     issue_cnt_q <= issue_cnt_q + 3'd1;
                  if (pending_q) begin
                     inst_buf_q[{recv_cnt_q, 3'b000} +: 8] <= mem_din_i;
                     recv_cnt_q <= recv_cnt_q + 2'd1;
                     if (recv_cnt_q == 2'd3) begin
                        state_q    <= VALID;
                        if_valid_q <= 1'b1;
                        if_pc_q    <= pc_q;
                        if_inst_q  <= {mem_din_i, inst_buf_q[23:0]};
                     end
                  end
               end
               VALID: begin
                  if (id_ready_i) begin
                     state_q     <= FETCH;
                     pc_q        <= pc_q + 32'd4;
                     issue_cnt_q <= 3'd0;
                     recv_cnt_q  <= 2'd0;
                     pending_q   <= 1'b0;
                     if_valid_q  <= 1'b0;
                  end
               end
               default: state_q <= FETCH;
            endcase
         end
      end
   end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; state clears immediately on assertion.
REQ-004 rdy  input  1  global ready; low freezes all state.
REQ-005 mem_grant_i  input  1  arbiter grants the byte memory port to fetch this cycle.
REQ-006 mem_din_i  input  8  byte returned one cycle after its address was issued.
REQ-007 mem_req_o  output  1  fetch requests the memory port.
REQ-008 mem_addr_o  output  32  byte address issued this cycle.
REQ-009 branch_i  input  1  redirect request from execute.
REQ-010 branch_target_i  input  32  redirect PC.
REQ-011 id_ready_i  input  1  if_id accepts the presented instruction.
REQ-012 if_valid_o  output  1  if_pc_o and if_inst_o hold a complete instruction.
REQ-013 if_pc_o  output  32  PC of the presented instruction.
REQ-014 if_inst_o  output  32  assembled instruction, little-endian.

Function
REQ-015 States SHALL be FETCH and VALID; no other states.
REQ-016 Internal registers SHALL be pc[31:0], issue_cnt[2:0] (0..4), recv_cnt[1:0], pending (1 bit) and inst_buf[31:0].
REQ-017 While rdy=0, no register SHALL change and all outputs SHALL hold their values.
REQ-018 In FETCH, mem_req_o SHALL be 1 while issue_cnt<4; in VALID it SHALL be 0.
REQ-019 Issue condition: FETCH, issue_cnt<4 and mem_grant_i=1; when met, mem_addr_o SHALL be pc+issue_cnt (mod 2^32), issue_cnt increments and pending<=1; otherwise mem_addr_o SHALL be 0 and pending<=0.
REQ-020 When pending=1, mem_din_i SHALL be written into inst_buf[8*recv_cnt+7:8*recv_cnt] and recv_cnt increments, regardless of the current mem_grant_i.
REQ-021 When the byte captured has recv_cnt=3, the state SHALL become VALID at that edge; if_valid_o=1, if_pc_o=pc, if_inst_o=assembled word.
REQ-022 With mem_grant_i held at 1, if_valid_o SHALL rise exactly 5 cycles after entering FETCH.
REQ-023 Grant loss SHALL stall issuing without losing captured bytes; fetch resumes at the next ungranted byte.
REQ-024 In VALID with id_ready_i=1 and branch_i=0: pc<=pc+4, counters and pending cleared, if_valid_o<=0, state FETCH.
REQ-025 In VALID with id_ready_i=0, all outputs SHALL remain stable.
REQ-026 branch_i=1 in any state (rdy=1) SHALL set pc<={branch_target_i[31:2],2'b00}, clear issue_cnt, recv_cnt, pending and if_valid_o, and enter FETCH.
REQ-027 branch_i SHALL take priority over id_ready_i; an instruction presented in that cycle counts as not consumed.
REQ-028 A byte in flight when a branch occurs SHALL be discarded; no byte of the old stream SHALL enter inst_buf.
REQ-029 pc+4 SHALL wrap modulo 2^32.

Reset
REQ-030 On rst=0: state FETCH, pc=RESET_PC, counters 0, pending 0, inst_buf 0, if_valid_o 0, if_pc_o 0, if_inst_o 0, mem_addr_o 0, mem_req_o 0.
REQ-031 Reset asserted mid-fetch SHALL abandon the fetch; after release, fetch restarts from RESET_PC byte 0.
REQ-032 After reset release, the first issue SHALL occur in the first cycle with rdy=1 and mem_grant_i=1.

Verification
REQ-033 Memory holds 13,05,00,00 at addresses 0..3, grant=1, ready=1 -> addresses 0,1,2,3 on consecutive cycles; valid at cycle 5 with if_pc_o=0 and if_inst_o=32'h00000513.
REQ-034 id_ready_i=0 for 10 cycles after valid -> outputs stable, mem_req_o=0; ready raised -> next fetch begins at 0x4.
REQ-035 Grant dropped for 3 cycles after byte 1 is issued -> byte 1 still captured; byte 2 issued at address pc+2 once grant returns; valid delayed by 3 cycles.
REQ-036 branch_i with target 0x103 after byte 2 is issued -> in-flight byte discarded; next issue at 0x100; if_pc_o=0x100 at valid.
REQ-037 rdy low for 4 cycles mid-fetch -> no counter or output change; result identical to the uninterrupted run except shifted by 4 cycles.
REQ-038 rst pulsed low while VALID at pc=0x20 -> if_valid_o drops immediately; refetch from RESET_PC.
